cipher_seq_ctrl: RTL and testbench

CIPHER_SEQ_CTRL -- requirements
Module: cipher_seq_ctrl

---
 rtl/cipher_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cipher_seq_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// cipher_seq_ctrl : buffers a message, feeds it to a per-character cipher
//                   core one character at a time, streams the ciphertext.
// Rev 1.0
// ==========================================================================
module cipher_seq_ctrl #(
    parameter int MSG_DEPTH = 16,
    localparam int IW = $clog2(MSG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    key_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic [1:0]    core_mode,
    output logic [7:0]    core_ptxt,
    output logic [7:0]    core_key,
    input  logic [7:0]    core_ctxt,
    input  logic          core_ready,
    input  logic          core_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [IW-1:0] err_pos
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [IW:0] LAST_SLOT = (IW+1)'(MSG_DEPTH - 1);
    localparam logic [IW:0] CNT_ONE   = (IW+1)'(1);

    logic [2:0]    state_q,     state_d;
    logic [7:0]    key_q,       key_d;
    logic [IW:0]   count_q,     count_d;
    logic [IW-1:0] rd_idx_q,    rd_idx_d;
    logic [7:0]    out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q,      done_d;
    logic [1:0]    err_code_q,  err_code_d;
    logic [IW-1:0] err_pos_q,   err_pos_d;

    logic [7:0]    msg_buf_q [MSG_DEPTH];

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_code_d  = err_code_q;
        err_pos_d   = err_pos_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    key_d      = key_in;
                    count_d    = '0;
                    rd_idx_d   = '0;
                    err_code_d = 2'b00;
                    err_pos_d  = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    count_d = count_q + CNT_ONE;
                    if (in_last || (count_q == LAST_SLOT)) begin
                        rd_idx_d = '0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // core_err is combinational on the character presented this cycle
                if (core_err) begin
                    err_code_d = 2'b01;
                    err_pos_d  = rd_idx_q;
                    state_d    = S_ERR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_ready) begin
                    out_data_d  = core_ctxt;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    err_code_d = 2'b10;
                    err_pos_d  = rd_idx_q;
                    state_d    = S_ERR;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if ({1'b0, rd_idx_q} == (count_q - CNT_ONE)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                        state_d  = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_q       <= 8'h00;
            count_q     <= '0;
            rd_idx_q    <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_code_q  <= 2'b00;
            err_pos_q   <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_code_q  <= err_code_d;
            err_pos_q   <= err_pos_d;
        end
    end

    // Storage only; every read is bounded by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if ((state_q == S_LOAD) && in_valid) begin
            msg_buf_q[count_q[IW-1:0]] <= in_data;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT) || (state_q == S_OUT);
    assign err       = (state_q == S_ERR);
    assign core_mode = (state_q == S_ISSUE) ? 2'b10 : 2'b00;
    assign core_ptxt = (state_q == S_ISSUE) ? msg_buf_q[rd_idx_q] : 8'h00;
    assign core_key  = key_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign err_code  = err_code_q;
    assign err_pos   = err_pos_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_seq_ctrl.sv
`default_nettype none
// Self-checking bench for cipher_seq_ctrl: reference vectors, corner sequences
// and randomized messages against a message-level model.
module tb_cipher_seq_ctrl;

    localparam int MSG_DEPTH = 16;
    localparam int IW = $clog2(MSG_DEPTH);

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_last, out_ready;
    logic [7:0]    key_in, in_data;
    logic          in_ready, out_valid, busy, done, err;
    logic [1:0]    core_mode, err_code;
    logic [7:0]    core_ptxt, core_key, core_ctxt, out_data;
    logic          core_ready, core_err;
    logic [IW-1:0] err_pos;

    bit            force_timeout;
    int            cyc;
    int            last_xfer_cyc;
    logic [7:0]    core_seen [$];
    int            n_checks, n_fail;

    typedef struct {
        logic [7:0] key;
        string      s;
        int         nexp;
        logic [7:0] ex [4];
        int         code;
        int         pos;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    cipher_seq_ctrl #(.MSG_DEPTH(MSG_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .core_mode(core_mode), .core_ptxt(core_ptxt), .core_key(core_key),
        .core_ctxt(core_ctxt), .core_ready(core_ready), .core_err(core_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_pos(err_pos)
    );

    // Stand-in cipher core: additive per-key offset, lowercase letters only.
    function automatic logic [7:0] key_off(input logic [7:0] k);
        case (k)
            8'h05:   return 8'hFB;
            8'h70:   return 8'h73;
            default: return k ^ 8'h5A;
        endcase
    endfunction

    function automatic bit char_ok(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

    assign core_err = (core_mode == 2'b10) && !char_ok(core_ptxt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            core_ready <= 1'b0;
            core_ctxt  <= 8'h00;
        end else begin
            core_ready <= (core_mode == 2'b10) && !core_err && !force_timeout;
            core_ctxt  <= core_ptxt + key_off(core_key);
            if (core_mode == 2'b10) core_seen.push_back(core_ptxt);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Message-level model: outputs up to the first bad character, buffer truncation.
    function automatic void model(input logic [7:0] k, input logic [7:0] cq [$],
                                  output logic [7:0] eq [$], output int code, output int pos);
        int n;
        n = (cq.size() > MSG_DEPTH) ? MSG_DEPTH : cq.size();
        eq = {};
        code = 0;
        pos = 0;
        for (int i = 0; i < n; i++) begin
            if (!char_ok(cq[i])) begin
                code = 1;
                pos = i;
                return;
            end
            eq.push_back(cq[i] + key_off(k));
        end
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_err"},       err,       0);
        check({tag, "_err_code"},  err_code,  0);
        check({tag, "_err_pos"},   err_pos,   0);
        check({tag, "_core_mode"}, core_mode, 0);
        check({tag, "_core_ptxt"}, core_ptxt, 0);
        check({tag, "_core_key"},  core_key,  0);
    endtask

    task automatic do_start(input logic [7:0] k);
        start = 1'b1;
        key_in = k;
        core_seen.delete();
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_after_start", err, 0);
        check("err_code_after_start", err_code, 0);
    endtask

    task automatic feed(input logic [7:0] cq [$], input bit use_last, input bit gaps, output int acc);
        int i = 0;
        int guard = 0;
        acc = 0;
        while (i < cq.size() && guard < 200) begin
            guard++;
            if (!in_ready) begin
                if (acc > 0) begin
                    // surplus character offered after the controller stopped accepting
                    in_valid = 1'b1; in_data = cq[i]; in_last = 1'b0;
                    @(posedge clk); #1;
                    break;
                end
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                in_valid = 1'b1;
                in_data  = cq[i];
                in_last  = use_last && (i == cq.size() - 1);
                @(posedge clk); #1;
                acc++;
                i++;
                last_xfer_cyc = cyc;
            end
        end
        if (guard >= 200) fail_now("feed_timeout", acc, cq.size());
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input logic [7:0] eq [$], input int code, input int pos,
                           input int pct, input bit timing);
        int got = 0;
        int guard = 0;
        int prev_x = -1;
        bit first = 1'b1, hold = 1'b0, just_last = 1'b0, fin = 1'b0;
        logic [7:0] held = 8'h00;
        while (!fin) begin
            guard++;
            if (guard > 1000) begin
                fail_now("collect_timeout", got, eq.size());
                fin = 1'b1;
            end else if (just_last) begin
                check("done_pulse", done, 1);
                check("busy_after_done", busy, 0);
                check("out_valid_after_done", out_valid, 0);
                check("core_issue_count", core_seen.size(), eq.size());
                @(posedge clk); #1;
                check("done_single", done, 0);
                fin = 1'b1;
            end else if (err) begin
                check("err_code", err_code, code);
                check("err_pos", err_pos, pos);
                check("outputs_before_err", got, eq.size());
                check("core_issue_count_err", core_seen.size(), pos + 1);
                check("busy_in_err", busy, 0);
                for (int j = 0; j < 4; j++) begin
                    check("out_valid_in_err", out_valid, 0);
                    @(posedge clk); #1;
                end
                fin = 1'b1;
            end else begin
                if (done) fail_now("done_early", done, 0);
                if (out_valid) begin
                    if (first && timing) check("first_out_latency", cyc - last_xfer_cyc, 2);
                    first = 1'b0;
                    if (hold) check("out_data_stable", out_data, held);
                    out_ready = ($urandom_range(1, 100) <= pct);
                    if (out_ready) begin
                        if (got < eq.size()) check("out_data", out_data, eq[got]);
                        else fail_now("extra_output", out_data, 0);
                        if (timing && prev_x >= 0) check("out_spacing", cyc - prev_x, 3);
                        prev_x = cyc;
                        got++;
                        hold = 1'b0;
                        just_last = (code == 0) && (got == eq.size());
                    end else begin
                        hold = 1'b1;
                        held = out_data;
                    end
                end else begin
                    if (hold) fail_now("out_valid_dropped", out_valid, 1);
                    hold = 1'b0;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic set_row(input int i, input logic [7:0] k, input string s, input int ne,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input int code, input int pos);
        tbl[i].key = k;
        tbl[i].s = s;
        tbl[i].nexp = ne;
        tbl[i].ex[0] = e0;
        tbl[i].ex[1] = e1;
        tbl[i].ex[2] = e2;
        tbl[i].ex[3] = 8'h00;
        tbl[i].code = code;
        tbl[i].pos = pos;
    endtask

    task automatic run_row(input int i);
        logic [7:0] cq [$];
        logic [7:0] eq [$];
        int acc;
        for (int j = 0; j < tbl[i].s.len(); j++) cq.push_back(tbl[i].s[j]);
        for (int j = 0; j < tbl[i].nexp; j++) eq.push_back(tbl[i].ex[j]);
        do_start(tbl[i].key);
        feed(cq, 1'b1, 1'b0, acc);
        check("row_accepted", acc, cq.size());
        collect(eq, tbl[i].code, tbl[i].pos, 100, 1'b1);
    endtask

    task automatic seq_full_buffer();
        logic [7:0] cq [$];
        logic [7:0] eq [$];
        int acc, code, pos;
        for (int j = 0; j <= MSG_DEPTH; j++) cq.push_back(8'(8'h61 + (j % 26)));
        model(8'h70, cq, eq, code, pos);
        do_start(8'h70);
        feed(cq, 1'b0, 1'b0, acc);
        check("full_accepted", acc, MSG_DEPTH);
        check("full_in_ready_low", in_ready, 0);
        collect(eq, code, pos, 100, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, out_valid, 1);
    endtask

    task automatic seq_stall();
        logic [7:0] cq [$];
        logic [7:0] eq [$];
        logic [7:0] held;
        int acc;
        cq = {8'h61, 8'h62, 8'h63};
        eq = {8'h5C, 8'h5D, 8'h5E};
        do_start(8'h05);
        feed(cq, 1'b1, 1'b0, acc);
        out_ready = 1'b0;
        wait_valid("stall_valid_seen");
        check("stall_first_data", out_data, 8'h5C);
        held = out_data;
        for (int j = 0; j < 5; j++) begin
            start  = (j == 1);
            key_in = 8'h33;
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held);
            check("stall_no_issue", core_mode, 0);
        end
        start = 1'b0;
        collect(eq, 0, 0, 100, 1'b0);
    endtask

    task automatic seq_timeout();
        logic [7:0] cq [$];
        logic [7:0] eq [$];
        int acc;
        cq = {8'h61, 8'h62};
        force_timeout = 1'b1;
        do_start(8'h05);
        feed(cq, 1'b1, 1'b0, acc);
        collect(eq, 2, 0, 100, 1'b0);
        force_timeout = 1'b0;
    endtask

    task automatic seq_reset_mid_out();
        logic [7:0] cq [$];
        int acc;
        cq = {8'h61, 8'h62, 8'h63};
        do_start(8'h70);
        feed(cq, 1'b1, 1'b0, acc);
        out_ready = 1'b0;
        wait_valid("pre_reset_valid");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset("mid_out_rst");
        run_row(0);
    endtask

    task automatic seq_random(input int nmsg);
        for (int m = 0; m < nmsg; m++) begin
            logic [7:0] cq [$];
            logic [7:0] eq [$];
            logic [7:0] k;
            int len, acc, code, pos, exp_acc;
            case ($urandom_range(0, 2))
                0:       k = 8'h05;
                1:       k = 8'h70;
                default: k = 8'($urandom_range(0, 255));
            endcase
            len = $urandom_range(1, MSG_DEPTH + 2);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) cq.push_back(8'(8'h21 + $urandom_range(0, 20)));
                else                            cq.push_back(8'(8'h61 + $urandom_range(0, 25)));
            end
            model(k, cq, eq, code, pos);
            exp_acc = (len > MSG_DEPTH) ? MSG_DEPTH : len;
            do_start(k);
            feed(cq, (len <= MSG_DEPTH), 1'b1, acc);
            check("rand_accepted", acc, exp_acc);
            collect(eq, code, pos, $urandom_range(30, 100), 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; key_in = 8'h00; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; out_ready = 1'b0; force_timeout = 1'b0;
        n_checks = 0; n_fail = 0; last_xfer_cyc = 0;

        set_row(0, 8'h05, "abc",  3, 8'h5C, 8'h5D, 8'h5E, 0, 0);
        set_row(1, 8'h70, "a",    1, 8'hD4, 8'h00, 8'h00, 0, 0);
        set_row(2, 8'h05, "ab!c", 2, 8'h5C, 8'h5D, 8'h00, 1, 2);
        set_row(3, 8'h70, "!",    0, 8'h00, 8'h00, 8'h00, 1, 0);
        set_row(4, 8'h70, "zy",   2, 8'hED, 8'hEC, 8'h00, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("por");

        for (int i = 0; i < 5; i++) run_row(i);
        seq_full_buffer();
        seq_stall();
        seq_timeout();
        seq_reset_mid_out();
        seq_random(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
